// File: rtl/fp_minmax_reduce_pkg.sv
// Shared types and constants for the FP32 min/max reduction block.
// Field helpers keep the NaN classification in one place.
package fp_minmax_reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic OP_MIN = 1'b0;
  localparam logic OP_MAX = 1'b1;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

  localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
  endfunction

  // Quiet bit is the mantissa MSB; clear means signaling.
  function automatic logic is_snan(input logic [FP_W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

endpackage

// File: rtl/fp_minmax_reduce_cmp.sv
// Combinational FP32 min/max of two operands with IEEE NaN handling.
// A single NaN operand is dropped; two NaNs collapse to the canonical NaN.
module fp_minmax_cmp
  import fp_minmax_reduce_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            op,
  output logic [FP_W-1:0] result,
  output logic            a_snan,
  output logic            b_snan
);

  logic a_nan;
  logic b_nan;
  logic a_lt_b;
  logic a_neg;
  logic b_neg;

  assign a_nan  = is_nan(a);
  assign b_nan  = is_nan(b);
  assign a_snan = is_snan(a);
  assign b_snan = is_snan(b);
  assign a_neg  = a[FP_W-1];
  assign b_neg  = b[FP_W-1];

  // Sign-magnitude ordering; a sign mismatch alone decides, so -0 < +0.
  always_comb begin
    if (a_neg != b_neg)
      a_lt_b = a_neg;
    else if (a_neg)
      a_lt_b = a[FP_W-2:0] > b[FP_W-2:0];
    else
      a_lt_b = a[FP_W-2:0] < b[FP_W-2:0];
  end

  always_comb begin
    if (a_nan && b_nan)
      result = CANON_NAN;
    else if (a_nan)
      result = b;
    else if (b_nan)
      result = a;
    else if (op == OP_MAX)
      result = a_lt_b ? b : a;
    else
      result = a_lt_b ? a : b;
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FP32 min/max reduction: IDLE -> ACCUM (one element per cycle) -> DONE.
// The accumulator starts as canonical NaN so the first real element always wins.
module fp_minmax_reduce
  import fp_minmax_reduce_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_data,
  output logic             out_nv,
  input  logic             out_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [FP_W-1:0]  acc;
  logic [LEN_W-1:0] cnt;
  logic             nv;
  logic             op_q;
  logic [FP_W-1:0]  cmp_result;
  logic             acc_snan;
  logic             data_snan;
  logic             beat;

  fp_minmax_cmp u_cmp (
    .a      (acc),
    .b      (in_data),
    .op     (op_q),
    .result (cmp_result),
    .a_snan (acc_snan),
    .b_snan (data_snan)
  );

  assign beat = in_valid && (state == ST_ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (beat && cnt == LEN_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      nv   <= 1'b0;
      op_q <= OP_MIN;
    end else if (state == ST_IDLE && start) begin
      acc  <= CANON_NAN;
      cnt  <= len;
      nv   <= 1'b0;
      op_q <= op;
    end else if (beat) begin
      acc <= cmp_result;
      cnt <= cnt - LEN_W'(1);
      // The accumulator never retains an sNaN, so acc_snan only guards corrupt state.
      nv  <= nv | data_snan | acc_snan;
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = out_valid ? acc : '0;
  assign out_nv    = out_valid && nv;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// compares every presented result (and its stability under backpressure).
module tb_fp_minmax_reduce;

  typedef struct packed {
    logic [31:0] d;
    logic        nv;
  } exp_t;

  typedef logic [31:0] vec_t [4];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_nv;
  logic        out_ready;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  fp_minmax_reduce #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_nv    (out_nv),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h with empty scoreboard at %0t", out_data, $time);
      end else begin
        check("out_data", out_data, exp_q[0].d);
        check("out_nv", {31'd0, out_nv}, {31'd0, exp_q[0].nv});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic o, input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1; op = o; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (i == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy still 1 after 50 cycles, expected 0", name);
    end
  endtask

  task automatic reduce(input string name, input logic o, input int n, input vec_t e,
                        input logic [31:0] xd, input logic xn);
    exp_q.push_back('{d: xd, nv: xn});
    do_start(o, n[7:0]);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = e[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({name, "_valid_latency"}, {31'd0, out_valid}, 32'd1);
    check({name, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    wait_idle(name);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_nv", {31'd0, out_nv}, 32'd0);
    #19 rst_n = 1'b1;

    reduce("min3", 1'b0, 3, '{32'h40400000, 32'hBFC00000, 32'h40000000, 32'h0}, 32'hBFC00000, 1'b0);
    reduce("zero_max", 1'b1, 2, '{32'h00000000, 32'h80000000, 32'h0, 32'h0}, 32'h00000000, 1'b0);
    reduce("zero_min", 1'b0, 2, '{32'h00000000, 32'h80000000, 32'h0, 32'h0}, 32'h80000000, 1'b0);
    reduce("qnan_drop", 1'b0, 2, '{32'h7FC00000, 32'h40A00000, 32'h0, 32'h0}, 32'h40A00000, 1'b0);
    reduce("snan_all", 1'b0, 2, '{32'h7F800001, 32'h7F800001, 32'h0, 32'h0}, 32'h7FC00000, 1'b1);
    reduce("neg_min", 1'b0, 4, '{32'hC0400000, 32'hC0000000, 32'h7FC00000, 32'hBF800000}, 32'hC0400000, 1'b0);
    reduce("neg_max", 1'b1, 4, '{32'hC0400000, 32'hC0000000, 32'h7FC00000, 32'hBF800000}, 32'hBF800000, 1'b0);
    reduce("equal", 1'b1, 2, '{32'h40000000, 32'h40000000, 32'h0, 32'h0}, 32'h40000000, 1'b0);
    reduce("len0", 1'b0, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 32'h7FC00000, 1'b0);

    // Backpressure: input gaps, stray starts while busy, result held 5 cycles.
    out_ready = 1'b0;
    exp_q.push_back('{d: 32'h3F800000, nv: 1'b1});
    do_start(1'b1, 8'd3);
    in_valid = 1'b1; in_data = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b1; op = 1'b0; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'hC0000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_still_accum", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 32'h7FA00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_valid_latency", {31'd0, out_valid}, 32'd1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bp_idle_after_hs", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("bp_start_ignored", {31'd0, busy}, 32'd0);

    // Abort mid-ACCUM; the sNaN already consumed must not leak into the next run.
    do_start(1'b0, 8'd4);
    in_valid = 1'b1; in_data = 32'h7F800001;
    @(posedge clk); #1;
    in_data = 32'hC0000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_out_nv", {31'd0, out_nv}, 32'd0);
    #14 rst_n = 1'b1;
    reduce("after_abort", 1'b0, 1, '{32'h3F800000, 32'h0, 32'h0, 32'h0}, 32'h3F800000, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_minmax_reduce.md
FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 The block SHALL expose parameter LEN_W, default 8, giving the width of the element-count input.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-005 op  input  1  0 = minimum, 1 = maximum; latched on accepted start.
REQ-006 len  input  LEN_W  number of FP32 elements to reduce; latched on accepted start; 0 legal.
REQ-007 in_valid  input  1  element beat valid.
REQ-008 in_data  input  32  IEEE-754 single-precision element.
REQ-009 in_ready  output  1  block accepts an element this cycle.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_data  output  32  reduced FP32 result.
REQ-013 out_nv  output  1  invalid flag: at least one signaling NaN was consumed.
REQ-014 out_ready  input  1  consumer accepts result.

Function
REQ-015 States SHALL be IDLE, ACCUM and DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 latches op and len, loads accumulator with canonical NaN 0x7FC00000, clears nv; next state is ACCUM if len!=0, DONE if len==0.
REQ-017 ACCUM: in_ready=1; each beat (in_valid&&in_ready) replaces accumulator with combine(acc, in_data) and decrements the remaining count.
REQ-018 The beat that decrements the count from 1 to 0 SHALL move the state to DONE, so out_valid rises on the cycle after the last accepted beat.
REQ-019 in_valid low cycles in ACCUM SHALL leave accumulator, count and nv unchanged.
REQ-020 DONE: out_valid=1, out_data=accumulator, out_nv=nv, in_ready=0; out_data and out_nv hold stable until out_valid&&out_ready, after which the state returns to IDLE the next cycle.
REQ-021 start SHALL be ignored while busy=1, including the handshake cycle in DONE.
REQ-022 A NaN is exponent 0xFF with a nonzero mantissa; a signaling NaN additionally has mantissa bit 22 = 0.
REQ-023 combine with exactly one NaN operand SHALL return the other operand.
REQ-024 combine with two NaN operands SHALL return 0x7FC00000.
REQ-025 combine with no NaN operand SHALL return the numerically smaller (op=0) or larger (op=1) value by sign/exponent/mantissa ordering, with -0 (0x80000000) treated as less than +0 (0x00000000).
REQ-026 combine with equal operands SHALL return that value.
REQ-027 nv SHALL be set sticky whenever an accepted in_data is a signaling NaN.
REQ-028 An all-NaN or len=0 reduction SHALL produce 0x7FC00000.
REQ-029 The combine step SHALL be purely combinational, giving one element per cycle throughput.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, accumulator 0x00000000, count 0, nv 0, and in_ready, busy, out_valid, out_data, out_nv all 0.
REQ-031 Reset asserted mid-ACCUM or mid-DONE SHALL abort the operation with no result emitted; the first start after release SHALL behave as a fresh reduction.

Structure
REQ-032 A shared package SHALL hold the state enum, the op encoding, the canonical NaN constant 0x7FC00000 and the field widths (sign 1, exponent 8, mantissa 23).
REQ-033 The combine logic SHALL be a separate combinational sub-module fp_minmax_cmp with inputs a, b and op, and output result plus an a_snan/b_snan indication.
REQ-034 The FSM, counter and accumulator SHALL live in fp_minmax_reduce.

Verification
REQ-035 op=0, len=3, elements 0x40400000, 0xBFC00000, 0x40000000 back-to-back -> out_valid on the cycle after the third beat, out_data=0xBFC00000, out_nv=0.
REQ-036 len=2, elements 0x00000000, 0x80000000 -> op=1 gives 0x00000000; op=0 gives 0x80000000.
REQ-037 op=0, elements 0x7FC00000, 0x40A00000 -> out_data=0x40A00000, out_nv=0; elements 0x7F800001, 0x7F800001 -> out_data=0x7FC00000, out_nv=1.
REQ-038 len=0 start -> out_valid=1 on the next cycle with out_data=0x7FC00000 and in_ready never asserted.
REQ-039 Backpressure case: in_valid gaps during ACCUM, out_ready held low 5 cycles in DONE, start pulsed while busy -> result stable throughout, extra start ignored, IDLE one cycle after handshake.
REQ-040 rst_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; a following len=1 reduction of 0x3F800000 returns 0x3F800000.
